peripheral_bus_arbiter: RTL and testbench
=========================================

PERIPHERAL_BUS_ARBITER -- requirements
Module: peripheral_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: ACCESS-state cycles with busy high before abort (1..255).
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-004 SHALL have ports m0_request/m1_request, input, 1 each: requester holds high until its ack.
REQ-005 SHALL have ports m0_we/m1_we, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports m0_address/m1_address, input, 12 each: peripheral bus address.
REQ-007 SHALL have ports m0_byteSelect/m1_byteSelect, input, 4 each: byte lanes.
REQ-008 SHALL have ports m0_dataWrite/m1_dataWrite, input, 32 each: write data.
REQ-009 SHALL have ports m0_dataRead/m1_dataRead, output, 32 each: read data, valid only with that requester's ack.
REQ-010 SHALL have ports m0_ack/m1_ack and m0_error/m1_error, output, 1 each: one-cycle completion pulse and error flag.
REQ-011 SHALL have ports peripheralBus_we, peripheralBus_oe (output, 1), peripheralBus_address (output, 12), peripheralBus_byteSelect (output, 4), peripheralBus_dataWrite (output, 32): shared register bus.
REQ-012 SHALL have ports peripheralBus_dataRead (input, 32), peripheralBus_requestOutput (input, 1: OR of all register oe claims), peripheralBus_busy (input, 1: slow peripheral stall).

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESPOND -> IDLE.
REQ-014 IDLE: on any request, SHALL grant by round-robin (requester not served last wins ties), latch its we/address/byteSelect/dataWrite, enter ACCESS next cycle.
REQ-015 ACCESS: SHALL drive latched fields on the bus, we = latched we, oe = !latched we; we and oe never both high.
REQ-016 ACCESS with busy low: SHALL capture dataRead, set error = read && !requestOutput, enter RESPOND.
REQ-017 ACCESS with busy high: SHALL hold bus outputs unchanged and remain in ACCESS.
REQ-018 RESPOND: SHALL pulse granted ack for exactly one cycle with captured data/error, update last-served pointer, return to IDLE; bus outputs low.
REQ-019 Latency: request sampled in IDLE at cycle N, busy low -> bus access cycle N+1, ack cycle N+2.
REQ-020 Requester SHALL drop request the cycle after ack; a request still high in IDLE is a new transaction.
REQ-021 Outside ACCESS all peripheralBus_* outputs SHALL be 0; non-granted ack/error SHALL be 0; mX_dataRead SHALL be 0 except with its ack.
REQ-022 Write transactions SHALL never flag error from requestOutput; byteSelect 0 SHALL pass through unchanged.
REQ-023 Requests arriving outside IDLE SHALL wait; no preemption.

Reset
REQ-024 rst SHALL force IDLE, all outputs 0, last-served = m1 (m0 wins first tie), timeout counter 0.
REQ-025 rst mid-ACCESS or mid-RESPOND SHALL abort with no ack emitted.

Configuration
REQ-026 With PERIPHERAL_BUS_ARBITER_TIMEOUT_EN defined: 8-bit counter in ACCESS; after TIMEOUT_CYCLES consecutive busy-high cycles SHALL enter RESPOND with error = 1, dataRead = 0.
REQ-027 Without it: ACCESS SHALL wait indefinitely on busy; TIMEOUT_CYCLES unused; no counter logic.

Structure
REQ-028 Shared package peripheral_bus_pkg SHALL hold address width 12, data width 32, FSM state encoding.
REQ-029 Sub-module peripheral_bus_rr_select SHALL hold the two-way round-robin grant and last-served pointer.

Verification
REQ-030 m0 write addr 0x104, data 0xA5A5A5A5, byteSelect 0xF, busy 0 -> peripheralBus_we high one cycle with those values, m0_ack two cycles after request, error 0.
REQ-031 m1 read addr 0x200, requestOutput 1, dataRead 0x12345678 -> m1_dataRead 0x12345678 with m1_ack, error 0; read with requestOutput 0 -> m1_error 1.
REQ-032 m0 and m1 request together three times back-to-back -> grants m0, m1, m0; no cycle with both acks.
REQ-033 busy high 10 cycles during read -> bus held 11 cycles, ack follows; with timeout macro and TIMEOUT_CYCLES 4, busy stuck -> error 1, dataRead 0 after 4 cycles.
REQ-034 rst asserted in ACCESS -> next cycle IDLE, all outputs 0, no ack; simultaneous requests then grant m0.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter.
// Holds the bus widths and the arbiter FSM state encoding.
// No ports.
package peripheral_bus_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BSEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } arb_state_e;

endpackage

// File: rtl/peripheral_bus_rr_select.sv
// Two-way round-robin grant with a last-served pointer.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   req0_i, req1_i - requester m0 / m1 pending
//   update_i       - record served_i as the last-served requester
//   served_i       - index of the requester just completed
//   grant_valid_o  - at least one request pending
//   grant_idx_o    - winning requester (0 = m0, 1 = m1)
module peripheral_bus_rr_select
    import peripheral_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    input  logic update_i,
    input  logic served_i,
    output logic grant_valid_o,
    output logic grant_idx_o
);

    // Reset to m1 so that m0 wins the first tie.
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= served_i;
        end
    end

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_idx_o   = 1'b0;
        if (req0_i && req1_i) begin
            grant_idx_o = ~last_q;
        end else if (req1_i) begin
            grant_idx_o = 1'b1;
        end
    end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Two-requester arbiter in front of a shared peripheral register bus.
// One transaction at a time: grant, drive the bus until the peripheral is
// not busy, then return data/error with a one-cycle ack.
// Optional macro: PERIPHERAL_BUS_ARBITER_TIMEOUT_EN aborts an access after
// TIMEOUT_CYCLES consecutive busy cycles with error = 1, data = 0.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   mX_request/we/address/byteSelect/dataWrite - requester X inputs
//   mX_dataRead/ack/error       - requester X response (valid with ack)
//   peripheralBus_*             - shared bus outputs (zero outside ACCESS)
//   peripheralBus_dataRead      - read data from the bus
//   peripheralBus_requestOutput - some register claimed the read
//   peripheralBus_busy          - slow peripheral stall
//
// state      | meaning
// ST_IDLE    | waiting for a request, bus idle
// ST_ACCESS  | latched transaction on the bus, waiting for busy low
// ST_RESPOND | ack pulse to the granted requester
module peripheral_bus_arbiter
    import peripheral_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_request,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BSEL_W-1:0] m0_byteSelect,
    input  logic [DATA_W-1:0] m0_dataWrite,
    output logic [DATA_W-1:0] m0_dataRead,
    output logic              m0_ack,
    output logic              m0_error,
    input  logic              m1_request,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BSEL_W-1:0] m1_byteSelect,
    input  logic [DATA_W-1:0] m1_dataWrite,
    output logic [DATA_W-1:0] m1_dataRead,
    output logic              m1_ack,
    output logic              m1_error,
    output logic              peripheralBus_we,
    output logic              peripheralBus_oe,
    output logic [ADDR_W-1:0] peripheralBus_address,
    output logic [BSEL_W-1:0] peripheralBus_byteSelect,
    output logic [DATA_W-1:0] peripheralBus_dataWrite,
    input  logic [DATA_W-1:0] peripheralBus_dataRead,
    input  logic              peripheralBus_requestOutput,
    input  logic              peripheralBus_busy
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    arb_state_e        state_q;
    logic              gnt_q;
    logic              bus_we_q;
    logic              bus_oe_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [BSEL_W-1:0] bus_bsel_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic              ack0_q, ack1_q;
    logic              err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              grant_valid;
    logic              grant_idx;
    logic              access_done;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt_q;
`endif

    peripheral_bus_rr_select u_rr (
        .clk           (clk),
        .rst           (rst),
        .req0_i        (m0_request),
        .req1_i        (m1_request),
        .update_i      (state_q == ST_RESPOND),
        .served_i      (gnt_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // A write never reports a missing register claim.
    always_comb begin
        access_done = !peripheralBus_busy;
        resp_data   = peripheralBus_dataRead;
        resp_err    = !bus_we_q && !peripheralBus_requestOutput;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
        // to_cnt_q counts busy cycles already spent; this is the last allowed one.
        if (peripheralBus_busy && (to_cnt_q == TIMEOUT_LAST)) begin
            access_done = 1'b1;
            resp_data   = '0;
            resp_err    = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_oe_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_bsel_q  <= '0;
            bus_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        gnt_q       <= grant_idx;
                        bus_we_q    <= grant_idx ? m1_we : m0_we;
                        bus_oe_q    <= grant_idx ? !m1_we : !m0_we;
                        bus_addr_q  <= grant_idx ? m1_address : m0_address;
                        bus_bsel_q  <= grant_idx ? m1_byteSelect : m0_byteSelect;
                        bus_wdata_q <= grant_idx ? m1_dataWrite : m0_dataWrite;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (access_done) begin
                        bus_we_q    <= 1'b0;
                        bus_oe_q    <= 1'b0;
                        bus_addr_q  <= '0;
                        bus_bsel_q  <= '0;
                        bus_wdata_q <= '0;
                        ack0_q      <= !gnt_q;
                        ack1_q      <= gnt_q;
                        err0_q      <= !gnt_q && resp_err;
                        err1_q      <= gnt_q && resp_err;
                        rdata0_q    <= gnt_q ? '0 : resp_data;
                        rdata1_q    <= gnt_q ? resp_data : '0;
                        state_q     <= ST_RESPOND;
                    end
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
                    to_cnt_q <= access_done ? 8'd0 : to_cnt_q + 8'd1;
`endif
                end
                ST_RESPOND: begin
                    ack0_q   <= 1'b0;
                    ack1_q   <= 1'b0;
                    err0_q   <= 1'b0;
                    err1_q   <= 1'b0;
                    rdata0_q <= '0;
                    rdata1_q <= '0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign peripheralBus_we         = bus_we_q;
    assign peripheralBus_oe         = bus_oe_q;
    assign peripheralBus_address    = bus_addr_q;
    assign peripheralBus_byteSelect = bus_bsel_q;
    assign peripheralBus_dataWrite  = bus_wdata_q;
    assign m0_ack      = ack0_q;
    assign m1_ack      = ack1_q;
    assign m0_error    = err0_q;
    assign m1_error    = err1_q;
    assign m0_dataRead = rdata0_q;
    assign m1_dataRead = rdata1_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Self-checking bench for peripheral_bus_arbiter: a transaction-level model
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_peripheral_bus_arbiter;

    localparam int TO_CYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_request = 0, m0_we = 0, m1_request = 0, m1_we = 0;
    logic [11:0] m0_address = 0, m1_address = 0;
    logic [3:0]  m0_byteSelect = 0, m1_byteSelect = 0;
    logic [31:0] m0_dataWrite = 0, m1_dataWrite = 0;
    logic [31:0] m0_dataRead, m1_dataRead;
    logic        m0_ack, m1_ack, m0_error, m1_error;
    logic        peripheralBus_we, peripheralBus_oe;
    logic [11:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic [31:0] peripheralBus_dataRead = 0;
    logic        peripheralBus_requestOutput = 0;
    logic        peripheralBus_busy = 0;

    always #5 clk = ~clk;

    peripheral_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .m0_request(m0_request), .m0_we(m0_we), .m0_address(m0_address),
        .m0_byteSelect(m0_byteSelect), .m0_dataWrite(m0_dataWrite),
        .m0_dataRead(m0_dataRead), .m0_ack(m0_ack), .m0_error(m0_error),
        .m1_request(m1_request), .m1_we(m1_we), .m1_address(m1_address),
        .m1_byteSelect(m1_byteSelect), .m1_dataWrite(m1_dataWrite),
        .m1_dataRead(m1_dataRead), .m1_ack(m1_ack), .m1_error(m1_error),
        .peripheralBus_we(peripheralBus_we), .peripheralBus_oe(peripheralBus_oe),
        .peripheralBus_address(peripheralBus_address),
        .peripheralBus_byteSelect(peripheralBus_byteSelect),
        .peripheralBus_dataWrite(peripheralBus_dataWrite),
        .peripheralBus_dataRead(peripheralBus_dataRead),
        .peripheralBus_requestOutput(peripheralBus_requestOutput),
        .peripheralBus_busy(peripheralBus_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase 0: no transaction, 1: transaction on the bus, 2: reply cycle
    int          m_phase = 0, m_who = 0, m_last = 1, m_busy_run = 0;
    logic        m_we = 0, m_err = 0;
    logic [11:0] m_addr = 0;
    logic [3:0]  m_bsel = 0;
    logic [31:0] m_wdata = 0, m_rdata = 0;
    int          m_win;

    function automatic int pick(input logic r0, input logic r1, input int last);
        if (r0 && r1) return (last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    assign m_win = pick(m0_request, m1_request, m_last);

    always @(posedge clk) begin
        if (rst) begin
            m_phase    <= 0;
            m_last     <= 1;
            m_busy_run <= 0;
        end else if (m_phase == 0) begin
            if (m0_request || m1_request) begin
                m_who      <= m_win;
                m_we       <= (m_win == 1) ? m1_we : m0_we;
                m_addr     <= (m_win == 1) ? m1_address : m0_address;
                m_bsel     <= (m_win == 1) ? m1_byteSelect : m0_byteSelect;
                m_wdata    <= (m_win == 1) ? m1_dataWrite : m0_dataWrite;
                m_busy_run <= 0;
                m_phase    <= 1;
            end
        end else if (m_phase == 1) begin
            if (!peripheralBus_busy) begin
                m_rdata <= peripheralBus_dataRead;
                m_err   <= !m_we && !peripheralBus_requestOutput;
                m_phase <= 2;
            end
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
            else if (m_busy_run + 1 == TO_CYC) begin
                m_rdata <= 32'd0;
                m_err   <= 1'b1;
                m_phase <= 2;
            end
`endif
            else begin
                m_busy_run <= m_busy_run + 1;
            end
        end else begin
            m_last  <= m_who;
            m_phase <= 0;
        end
    end

    logic e_act, e_ack0, e_ack1;
    assign e_act  = (m_phase == 1);
    assign e_ack0 = (m_phase == 2) && (m_who == 0);
    assign e_ack1 = (m_phase == 2) && (m_who == 1);

    // ---------------- per-cycle compare + monitor ----------------
    logic        chk_en = 1'b0;
    int          bus_cnt = 0, we_cnt = 0, ack_cnt = 0;
    logic [11:0] last_addr = 0;
    logic [3:0]  last_bsel = 0;
    logic [31:0] last_wdata = 0;
    int          ack_seq[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("bus_we",    32'(peripheralBus_we), 32'(e_act && m_we));
            check("bus_oe",    32'(peripheralBus_oe), 32'(e_act && !m_we));
            check("bus_addr",  32'(peripheralBus_address), e_act ? 32'(m_addr) : 32'd0);
            check("bus_bsel",  32'(peripheralBus_byteSelect), e_act ? 32'(m_bsel) : 32'd0);
            check("bus_wdata", peripheralBus_dataWrite, e_act ? m_wdata : 32'd0);
            check("we_oe_excl", 32'(peripheralBus_we & peripheralBus_oe), 32'd0);
            check("m0_ack",    32'(m0_ack), 32'(e_ack0));
            check("m1_ack",    32'(m1_ack), 32'(e_ack1));
            check("both_acks", 32'(m0_ack & m1_ack), 32'd0);
            check("m0_error",  32'(m0_error), 32'(e_ack0 && m_err));
            check("m1_error",  32'(m1_error), 32'(e_ack1 && m_err));
            check("m0_dataRead", m0_dataRead, e_ack0 ? m_rdata : 32'd0);
            check("m1_dataRead", m1_dataRead, e_ack1 ? m_rdata : 32'd0);
            if (peripheralBus_we || peripheralBus_oe) begin
                bus_cnt    <= bus_cnt + 1;
                last_addr  <= peripheralBus_address;
                last_bsel  <= peripheralBus_byteSelect;
                last_wdata <= peripheralBus_dataWrite;
            end
            if (peripheralBus_we) we_cnt <= we_cnt + 1;
            if (m0_ack) ack_seq.push_back(0);
            if (m1_ack) ack_seq.push_back(1);
            if (m0_ack || m1_ack) ack_cnt <= ack_cnt + 1;
        end
    end

    // ---------------- requester helpers ----------------
    task automatic start_req(input int m, input logic we, input logic [11:0] a,
                             input logic [3:0] bs, input logic [31:0] wd);
        if (m == 0) begin
            m0_we = we; m0_address = a; m0_byteSelect = bs; m0_dataWrite = wd; m0_request = 1'b1;
        end else begin
            m1_we = we; m1_address = a; m1_byteSelect = bs; m1_dataWrite = wd; m1_request = 1'b1;
        end
    endtask

    task automatic drop_req(input int m);
        if (m == 0) m0_request = 1'b0;
        else        m1_request = 1'b0;
    endtask

    task automatic wait_ack(input int m, input int limit, output int at,
                            output logic [31:0] rd, output logic er);
        at = -1; rd = '0; er = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin
                at = cyc;
                rd = (m == 0) ? m0_dataRead : m1_dataRead;
                er = (m == 0) ? m0_error : m1_error;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_wait m%0d: no ack within %0d cycles", m, limit);
        end
    endtask

    // Raise a request, wait for its ack, drop it the cycle after.
    // lat = ack cycle minus the cycle the request was first presented.
    task automatic txn(input int m, input logic we, input logic [11:0] a,
                       input logic [3:0] bs, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er);
        int c0, at;
        @(posedge clk); #1;
        c0 = cyc;
        start_req(m, we, a, bs, wd);
        wait_ack(m, 60, at, rd, er);
        lat = at - c0;
        @(posedge clk); #1;
        drop_req(m);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int          lat, lat0a, lat0b, lat1, b0, w0, a0, c0;
        logic [31:0] rd, rd0a, rd0b, rd1;
        logic        er, er0a, er0b, er1;

        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_flags", 32'({peripheralBus_we, peripheralBus_oe, m0_ack, m1_ack, m0_error, m1_error}), 32'd0);
        check("rst_bus_addr", 32'(peripheralBus_address), 32'd0);
        check("rst_m0_data", m0_dataRead, 32'd0);

        // m0 write: bus one cycle, ack two cycles after request
        b0 = bus_cnt; w0 = we_cnt;
        txn(0, 1'b1, 12'h104, 4'hF, 32'hA5A5_A5A5, lat, rd, er);
        check("wr_latency", lat, 32'd2);
        check("wr_bus_cycles", bus_cnt - b0, 32'd1);
        check("wr_we_cycles", we_cnt - w0, 32'd1);
        check("wr_addr", 32'(last_addr), 32'h104);
        check("wr_data", last_wdata, 32'hA5A5_A5A5);
        check("wr_bsel", 32'(last_bsel), 32'hF);
        check("wr_err", 32'(er), 32'd0);

        // m1 read, register claims it
        peripheralBus_dataRead = 32'h1234_5678;
        peripheralBus_requestOutput = 1'b1;
        txn(1, 1'b0, 12'h200, 4'hF, 32'h0, lat, rd, er);
        check("rd_latency", lat, 32'd2);
        check("rd_data", rd, 32'h1234_5678);
        check("rd_err", 32'(er), 32'd0);
        check("rd_addr", 32'(last_addr), 32'h200);

        // m1 read, nobody claims it
        peripheralBus_requestOutput = 1'b0;
        txn(1, 1'b0, 12'h200, 4'hF, 32'h0, lat, rd, er);
        check("rd_unclaimed_err", 32'(er), 32'd1);

        // write with no claim and byteSelect 0: no error, lanes pass through
        peripheralBus_dataRead = 32'h0;
        w0 = we_cnt;
        txn(0, 1'b1, 12'h008, 4'h0, 32'h0000_00FF, lat, rd, er);
        check("wr_bsel0_err", 32'(er), 32'd0);
        check("wr_bsel0_lanes", 32'(last_bsel), 32'h0);
        check("wr_bsel0_we", we_cnt - w0, 32'd1);
        txn(1, 1'b1, 12'h3FC, 4'h3, 32'hDEAD_BEEF, lat, rd, er);
        check("wr_m1_err", 32'(er), 32'd0);
        check("wr_m1_data", last_wdata, 32'hDEAD_BEEF);

        // simultaneous requests, last served m1: grants m0, m1, m0
        ack_seq.delete();
        fork
            begin
                txn(0, 1'b1, 12'h010, 4'hF, 32'h1111_1111, lat0a, rd0a, er0a);
                txn(0, 1'b1, 12'h014, 4'hF, 32'h2222_2222, lat0b, rd0b, er0b);
            end
            txn(1, 1'b1, 12'h020, 4'hF, 32'h3333_3333, lat1, rd1, er1);
        join
        check("rr_count", ack_seq.size(), 32'd3);
        check("rr_first",  (ack_seq.size() > 0) ? ack_seq[0] : -1, 32'd0);
        check("rr_second", (ack_seq.size() > 1) ? ack_seq[1] : -1, 32'd1);
        check("rr_third",  (ack_seq.size() > 2) ? ack_seq[2] : -1, 32'd0);
        check("rr_lat_m0a", lat0a, 32'd2);
        check("rr_lat_m1",  lat1, 32'd5);
        check("rr_lat_m0b", lat0b, 32'd4);

        // short stall: two busy cycles
        peripheralBus_dataRead = 32'h0BAD_CAFE;
        peripheralBus_requestOutput = 1'b1;
        b0 = bus_cnt;
        fork
            txn(0, 1'b0, 12'h030, 4'hF, 32'h0, lat, rd, er);
            begin
                @(posedge clk); #1;
                peripheralBus_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                peripheralBus_busy = 1'b0;
            end
        join
        check("stall2_bus_cycles", bus_cnt - b0, 32'd3);
        check("stall2_latency", lat, 32'd4);
        check("stall2_data", rd, 32'h0BAD_CAFE);

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
        // busy stuck: abort after TO_CYC busy cycles
        b0 = bus_cnt;
        fork
            txn(0, 1'b0, 12'h040, 4'hF, 32'h0, lat, rd, er);
            begin
                @(posedge clk); #1;
                peripheralBus_busy = 1'b1;
                repeat (8) @(posedge clk);
                #1;
                peripheralBus_busy = 1'b0;
            end
        join
        check("timeout_bus_cycles", bus_cnt - b0, 32'd4);
        check("timeout_latency", lat, 32'd5);
        check("timeout_data", rd, 32'd0);
        check("timeout_err", 32'(er), 32'd1);
`else
        // ten busy cycles: bus held eleven, ack right after
        peripheralBus_dataRead = 32'hCAFE_F00D;
        b0 = bus_cnt;
        fork
            txn(0, 1'b0, 12'h040, 4'hF, 32'h0, lat, rd, er);
            begin
                @(posedge clk); #1;
                peripheralBus_busy = 1'b1;
                repeat (11) @(posedge clk);
                #1;
                peripheralBus_busy = 1'b0;
            end
        join
        check("stall10_bus_cycles", bus_cnt - b0, 32'd11);
        check("stall10_latency", lat, 32'd12);
        check("stall10_data", rd, 32'hCAFE_F00D);
        check("stall10_err", 32'(er), 32'd0);
`endif

        // reset during ACCESS (last served is m0 here)
        @(posedge clk); #1;
        c0 = cyc;
        start_req(0, 1'b0, 12'h0AA, 4'hF, 32'h0);
        @(posedge clk); #1;
        a0 = ack_cnt;
        rst = 1'b1;
        drop_req(0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_access_cycle", cyc - c0, 32'd2);
        check("rst_abort_flags", 32'({peripheralBus_we, peripheralBus_oe, m0_ack, m1_ack, m0_error, m1_error}), 32'd0);
        check("rst_abort_addr", 32'(peripheralBus_address), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_abort_no_ack", ack_cnt - a0, 32'd0);

        ack_seq.delete();
        fork
            txn(0, 1'b1, 12'h050, 4'hF, 32'h4444_4444, lat0a, rd0a, er0a);
            txn(1, 1'b1, 12'h060, 4'hF, 32'h5555_5555, lat1, rd1, er1);
        join
        check("post_rst_first", (ack_seq.size() > 0) ? ack_seq[0] : -1, 32'd0);
        check("post_rst_lat_m0", lat0a, 32'd2);
        check("post_rst_lat_m1", lat1, 32'd5);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
